// File: rtl/dii_flat_pkg.sv
// rtl/dii_flat_pkg.sv - shared types and helpers for the flat DII packet mux
// Purpose: flit width, mux FSM state type, flit record and the round-robin
//          index wrap helper used by the arbiter.
// Ports:   none (package).
package dii_flat_pkg;

   localparam int DII_FLIT_W = 16;

   typedef enum logic {
      IDLE = 1'b0,
      PKT  = 1'b1
   } dii_mux_state_t;

   typedef struct packed {
      logic [DII_FLIT_W-1:0] data;
      logic                  first;
      logic                  last;
   } dii_flit_t;

   // Lane index reached by stepping 'off' places past 'base' in a ring of n lanes.
   function automatic int dii_wrap_idx(input int base, input int off, input int n);
      return (base + off) % n;
   endfunction

endpackage

// File: rtl/dii_rr_arbiter.sv
// rtl/dii_rr_arbiter.sv - combinational round-robin request picker
// Purpose: picks the first set request bit scanning upward from ptr+1 with
//          wrap-around. Holds no state; the caller owns the priority pointer.
// Ports:
//   req        in   N      request vector
//   ptr        in   SELW   last-served lane; it has lowest priority
//   gnt        out  N      one-hot grant (all zero when no request)
//   idx        out  SELW   binary index of the granted lane (0 when none)
//   gnt_valid  out  1      at least one request present
module dii_rr_arbiter
   import dii_flat_pkg::*;
#(
   parameter int N    = 2,
   parameter int SELW = 1
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [N-1:0]    gnt,
   output logic [SELW-1:0] idx,
   output logic            gnt_valid
);

   always_comb begin
      int c;
      c         = 0;
      gnt       = '0;
      idx       = '0;
      gnt_valid = 1'b0;
      // Offset N lands back on ptr itself, so the last-served lane is still
      // granted when it is the only requester.
      for (int k = 1; k <= N; k++) begin
         c = dii_wrap_idx(int'(ptr), k, N);
         if (!gnt_valid && req[c]) begin
            gnt_valid = 1'b1;
            gnt[c]    = 1'b1;
            idx       = SELW'(c);
         end
      end
   end

endmodule

// File: rtl/dii_flat_packet_mux.sv
// rtl/dii_flat_packet_mux.sv - packet-atomic round-robin merge of N flat DII lanes
// Purpose: merges N 16-bit DII lanes onto one channel. A lane is granted on a
//          first-flagged flit and keeps the output until its last-flagged flit.
// Config:  DII_FLAT_MUX_OUTREG_EN defined -> outputs from one pipeline register
//          (latency 1). Undefined -> outputs combinational from the granted lane.
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   in_data    in   N*16   lane i flit = in_data[16*i +: 16]
//   in_first   in   N      per-lane first flag
//   in_last    in   N      per-lane last flag
//   in_valid   in   N      per-lane valid
//   in_ready   out  N      per-lane ready, at most one bit set
//   out_data   out  16     merged flit
//   out_first  out  1      merged first flag
//   out_last   out  1      merged last flag
//   out_valid  out  1      merged valid
//   out_ready  in   1      downstream ready
//   out_sel    out  SELW   lane owning the current output flit
module dii_flat_packet_mux
   import dii_flat_pkg::*;
#(
   parameter int  N    = 2,
   localparam int SELW = (N > 1) ? $clog2(N) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N*DII_FLIT_W-1:0] in_data,
   input  logic [N-1:0]            in_first,
   input  logic [N-1:0]            in_last,
   input  logic [N-1:0]            in_valid,
   output logic [N-1:0]            in_ready,
   output logic [DII_FLIT_W-1:0]   out_data,
   output logic                    out_first,
   output logic                    out_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [SELW-1:0]         out_sel
);

   dii_mux_state_t  state;
   logic [SELW-1:0] prio_ptr;
   logic [SELW-1:0] lock_g;

   logic [N-1:0]    req;
   logic [N-1:0]    arb_gnt;
   logic [SELW-1:0] arb_idx;
   logic            arb_any;

   dii_flit_t       lane_flit [N];
   dii_flit_t       cur_flit;
   logic [SELW-1:0] sel;
   logic            owned;
   logic            cur_valid;
   logic            path_ready;
   logic            xfer;

   for (genvar i = 0; i < N; i++) begin : g_lane
      assign lane_flit[i] = '{data:  in_data[DII_FLIT_W*i +: DII_FLIT_W],
                              first: in_first[i],
                              last:  in_last[i]};
   end

   // Only a first-flagged flit may open a packet; a stray continuation flit on
   // an idle lane never requests and therefore stalls on its own lane.
   assign req = (state == IDLE) ? (in_valid & in_first) : '0;

   dii_rr_arbiter #(
      .N    (N),
      .SELW (SELW)
   ) u_arb (
      .req       (req),
      .ptr       (prio_ptr),
      .gnt       (arb_gnt),
      .idx       (arb_idx),
      .gnt_valid (arb_any)
   );

   // Ownership and ready are gated by rst_n so that nothing is offered or
   // accepted while reset is held, even on the combinational output path.
   always_comb begin
      owned    = 1'b0;
      sel      = '0;
      in_ready = '0;
      if (rst_n) begin
         if (state == PKT) begin
            owned            = 1'b1;
            sel              = lock_g;
            in_ready[lock_g] = path_ready;
         end else if (arb_any) begin
            owned    = 1'b1;
            sel      = arb_idx;
            in_ready = arb_gnt & {N{path_ready}};
         end
      end
   end

   assign cur_flit  = lane_flit[sel];
   assign cur_valid = owned & in_valid[sel];
   assign xfer      = cur_valid & path_ready;

   // A request arriving with the closing flit is only seen next cycle, after
   // prio_ptr has moved past the lane that just finished.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         prio_ptr <= SELW'(N - 1);
         lock_g   <= '0;
      end else if (xfer) begin
         if (state == IDLE) begin
            if (cur_flit.last) begin
               prio_ptr <= arb_idx;
            end else begin
               state  <= PKT;
               lock_g <= arb_idx;
            end
         end else if (cur_flit.last) begin
            state    <= IDLE;
            prio_ptr <= lock_g;
         end
      end
   end

`ifdef DII_FLAT_MUX_OUTREG_EN
   dii_flit_t       out_q;
   logic            out_valid_q;
   logic [SELW-1:0] out_sel_q;

   // Refill the register whenever it is empty or being drained this cycle.
   assign path_ready = !out_valid_q || out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q       <= '0;
         out_valid_q <= 1'b0;
         out_sel_q   <= '0;
      end else if (path_ready) begin
         out_valid_q <= cur_valid;
         if (cur_valid) begin
            out_q     <= cur_flit;
            out_sel_q <= sel;
         end
      end
   end

   assign out_data  = out_q.data;
   assign out_first = out_q.first;
   assign out_last  = out_q.last;
   assign out_valid = out_valid_q;
   assign out_sel   = out_sel_q;
`else
   assign path_ready = out_ready;

   assign out_valid = cur_valid;
   assign out_data  = cur_valid ? cur_flit.data  : '0;
   assign out_first = cur_valid ? cur_flit.first : 1'b0;
   assign out_last  = cur_valid ? cur_flit.last  : 1'b0;
   assign out_sel   = sel;
`endif

endmodule
